fir_axis_decimator: RTL and testbench

Multichannel AXI-Stream decimate-by-D stage that sits directly downstream of `fir_multichannel_axis`. It consumes the TID-tagged filtered stream and keeps every D-th sample per channel, with an independent phase per channel. It re-frames the kept samples with a per-channel `tlast` every FRAME_LEN outputs. A 2-entry skid buffer gives full throughput under backpressure.

---
 rtl/fir_axis_decimator.sv | 227 ++++++++++++++++++++++
 tb/tb_fir_axis_decimator.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_axis_decimator.sv
// fir_axis_decimator
//   Multichannel AXI-Stream decimate-by-D stage. Keeps every D-th sample of
//   each TID-tagged channel (independent phase per channel), re-frames the
//   kept samples with a per-channel tlast every FRAME_LEN outputs, and buffers
//   them in a 2-entry skid buffer so the stage runs at full rate under
//   backpressure.
//
// Ports
//   aclk, aresetn        clock (rising edge) / async active-low reset
//   s_axis_t*            filtered input stream (tlast ignored)
//   m_axis_t*            decimated output stream, tlast marks end of frame
//   decim_factor         requested D; 0 -> 1, >MAX_DECIM -> MAX_DECIM
//   kept_count           kept samples accepted since reset (wraps)
//   bad_tid_count        accepted samples with tid >= N_CHANNELS (saturates)
module fir_axis_decimator #(
  parameter int N_CHANNELS = 4,
  parameter int DATA_WIDTH = 16,
  parameter int TID_WIDTH  = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
  parameter int MAX_DECIM  = 16,
  parameter int FRAME_LEN  = 64,
  localparam int DEC_WIDTH = $clog2(MAX_DECIM + 1)
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [TID_WIDTH-1:0]  s_axis_tid,
  input  logic                  s_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [TID_WIDTH-1:0]  m_axis_tid,
  output logic                  m_axis_tlast,
  input  logic [DEC_WIDTH-1:0]  decim_factor,
  output logic [31:0]           kept_count,
  output logic [15:0]           bad_tid_count
);

  localparam int PH_WIDTH = (MAX_DECIM > 1) ? $clog2(MAX_DECIM) : 1;
  localparam int OC_WIDTH = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  // Per-channel phase / frame counters
  logic [PH_WIDTH-1:0] ph_q [N_CHANNELS];
  logic [PH_WIDTH-1:0] ph_d [N_CHANNELS];
  logic [OC_WIDTH-1:0] oc_q [N_CHANNELS];
  logic [OC_WIDTH-1:0] oc_d [N_CHANNELS];

  // Configuration
  logic [DEC_WIDTH-1:0] d_reg_q, d_reg_d, d_clamped;
  logic                 cfg_pending_q, cfg_pending_d;

  // Output register and skid register
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [TID_WIDTH-1:0]  out_tid_q, out_tid_d;
  logic                  out_last_q, out_last_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic [TID_WIDTH-1:0]  skid_tid_q, skid_tid_d;
  logic                  skid_last_q, skid_last_d;

  logic        s_ready_q, s_ready_d;
  logic [31:0] kept_cnt_q, kept_cnt_d;
  logic [15:0] bad_cnt_q, bad_cnt_d;

  logic                accept, tid_ok, kept, new_last, drain, cfg_change;
  logic [PH_WIDTH-1:0] ph_sel, ph_wrap;
  logic [OC_WIDTH-1:0] oc_sel, oc_wrap;

  always_comb begin
    d_clamped = decim_factor;
    if (decim_factor == '0) begin
      d_clamped = DEC_WIDTH'(1);
    end else if (decim_factor > DEC_WIDTH'(MAX_DECIM)) begin
      d_clamped = DEC_WIDTH'(MAX_DECIM);
    end
  end

  // A change request is raised for exactly one cycle; the pending flag itself
  // masks a second request while D_reg has not yet caught up.
  assign cfg_change = (d_clamped != d_reg_q) && !cfg_pending_q;

  assign accept = s_axis_tvalid && s_ready_q;
  assign tid_ok = (int'(s_axis_tid) < N_CHANNELS);
  assign drain  = out_valid_q && m_axis_tready;

  always_comb begin
    ph_sel = '0;
    oc_sel = '0;
    for (int c = 0; c < N_CHANNELS; c++) begin
      if (s_axis_tid == TID_WIDTH'(c)) begin
        ph_sel = ph_q[c];
        oc_sel = oc_q[c];
      end
    end
  end

  assign kept     = accept && tid_ok && (ph_sel == '0);
  assign new_last = (oc_sel == OC_WIDTH'(FRAME_LEN - 1));
  assign ph_wrap  = ((DEC_WIDTH'(ph_sel) + DEC_WIDTH'(1)) >= d_reg_q) ? '0 : ph_sel + PH_WIDTH'(1);
  assign oc_wrap  = new_last ? '0 : oc_sel + OC_WIDTH'(1);

  always_comb begin
    ph_d          = ph_q;
    oc_d          = oc_q;
    d_reg_d       = d_reg_q;
    cfg_pending_d = cfg_change;
    kept_cnt_d    = kept_cnt_q;
    bad_cnt_d     = bad_cnt_q;

    if (cfg_pending_q) begin
      d_reg_d = d_clamped;
    end

    for (int c = 0; c < N_CHANNELS; c++) begin
      if (cfg_pending_q) begin
        ph_d[c] = '0;
        oc_d[c] = '0;
      end else if (accept && (s_axis_tid == TID_WIDTH'(c))) begin
        ph_d[c] = ph_wrap;
        if (ph_sel == '0) begin
          oc_d[c] = oc_wrap;
        end
      end
    end

    if (kept) begin
      kept_cnt_d = kept_cnt_q + 32'd1;
    end
    if (accept && !tid_ok && (bad_cnt_q != 16'hFFFF)) begin
      bad_cnt_d = bad_cnt_q + 16'd1;
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_tid_d    = out_tid_q;
    out_last_d   = out_last_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_tid_d   = skid_tid_q;
    skid_last_d  = skid_last_q;

    if (!out_valid_q || drain) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_tid_d    = skid_tid_q;
        out_last_d   = skid_last_q;
        skid_valid_d = kept;
        if (kept) begin
          skid_data_d = s_axis_tdata;
          skid_tid_d  = s_axis_tid;
          skid_last_d = new_last;
        end
      end else begin
        out_valid_d = kept;
        if (kept) begin
          out_data_d = s_axis_tdata;
          out_tid_d  = s_axis_tid;
          out_last_d = new_last;
        end
      end
    end else if (kept) begin
      // Output stalled: ready was only high because the skid was empty.
      skid_valid_d = 1'b1;
      skid_data_d  = s_axis_tdata;
      skid_tid_d   = s_axis_tid;
      skid_last_d  = new_last;
    end

    s_ready_d = !skid_valid_d && !cfg_change;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int c = 0; c < N_CHANNELS; c++) begin
        ph_q[c] <= '0;
        oc_q[c] <= '0;
      end
      d_reg_q       <= DEC_WIDTH'(1);
      cfg_pending_q <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_tid_q     <= '0;
      out_last_q    <= 1'b0;
      skid_valid_q  <= 1'b0;
      skid_data_q   <= '0;
      skid_tid_q    <= '0;
      skid_last_q   <= 1'b0;
      s_ready_q     <= 1'b0;
      kept_cnt_q    <= '0;
      bad_cnt_q     <= '0;
    end else begin
      ph_q          <= ph_d;
      oc_q          <= oc_d;
      d_reg_q       <= d_reg_d;
      cfg_pending_q <= cfg_pending_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_tid_q     <= out_tid_d;
      out_last_q    <= out_last_d;
      skid_valid_q  <= skid_valid_d;
      skid_data_q   <= skid_data_d;
      skid_tid_q    <= skid_tid_d;
      skid_last_q   <= skid_last_d;
      s_ready_q     <= s_ready_d;
      kept_cnt_q    <= kept_cnt_d;
      bad_cnt_q     <= bad_cnt_d;
    end
  end

  assign s_axis_tready = s_ready_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tid    = out_tid_q;
  assign m_axis_tlast  = out_last_q;
  assign kept_count    = kept_cnt_q;
  assign bad_tid_count = bad_cnt_q;

  // Input tlast carries no meaning here; framing is regenerated per channel.
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;

endmodule

// File: tb/tb_fir_axis_decimator.sv
module tb_fir_axis_decimator;

  localparam int NCH  = 3;
  localparam int DW   = 16;
  localparam int TW   = 2;
  localparam int MAXD = 16;
  localparam int FL   = 4;
  localparam int DECW = 5;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [DW-1:0] s_axis_tdata;
  logic [TW-1:0] s_axis_tid;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic [TW-1:0] m_axis_tid;
  logic [DECW-1:0] decim_factor;
  logic [31:0]   kept_count;
  logic [15:0]   bad_tid_count;

  always #5 aclk = ~aclk;

  fir_axis_decimator #(
    .N_CHANNELS(NCH), .DATA_WIDTH(DW), .TID_WIDTH(TW),
    .MAX_DECIM(MAXD), .FRAME_LEN(FL)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tid(s_axis_tid), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tid(m_axis_tid), .m_axis_tlast(m_axis_tlast),
    .decim_factor(decim_factor), .kept_count(kept_count), .bad_tid_count(bad_tid_count)
  );

  typedef struct packed {
    logic [TW-1:0] tid;
    logic          last;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    logic [TW-1:0] tid;
    logic [DW-1:0] data;
    logic          exp_v;
    logic [DW-1:0] exp_d;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state (kept up to date by the monitor thread)
  exp_t        exp_q[$];
  int          ph_m[NCH];
  int          oc_m[NCH];
  int          d_m = 1;
  int unsigned kept_m = 0;
  int          bad_m = 0;
  int          acc_count = 0;
  logic [7:0]  ch1_last_bits = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int clampd(input int v);
    if (v == 0) return 1;
    if (v > MAXD) return MAXD;
    return v;
  endfunction

  task automatic monitor();
    logic          hold_prev = 1'b0;
    exp_t          held;
    exp_t          e;
    int            t;
    forever begin
      @(posedge aclk);
      if (!aresetn) begin
        exp_q.delete();
        for (int c = 0; c < NCH; c++) begin ph_m[c] = 0; oc_m[c] = 0; end
        d_m = 1; kept_m = 0; bad_m = 0; hold_prev = 1'b0;
      end else begin
        if (hold_prev)
          check("axis_stable", 32'({m_axis_tvalid, m_axis_tid, m_axis_tlast, m_axis_tdata}),
                32'({1'b1, held}));
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            check("out_expected", 32'(0), 32'(1));
          end else begin
            e = exp_q.pop_front();
            check("out_sample", 32'({m_axis_tid, m_axis_tlast, m_axis_tdata}), 32'(e));
          end
          if (m_axis_tid == 2'd1) ch1_last_bits = {ch1_last_bits[6:0], m_axis_tlast};
        end
        hold_prev = m_axis_tvalid && !m_axis_tready;
        held = '{tid: m_axis_tid, last: m_axis_tlast, data: m_axis_tdata};

        if (s_axis_tvalid && s_axis_tready) begin
          acc_count++;
          t = int'(s_axis_tid);
          if (t >= NCH) begin
            if (bad_m < 16'hFFFF) bad_m++;
          end else begin
            if (ph_m[t] == 0) begin
              exp_q.push_back('{tid: s_axis_tid, last: (oc_m[t] == FL - 1), data: s_axis_tdata});
              oc_m[t] = (oc_m[t] + 1) % FL;
              kept_m++;
            end
            ph_m[t] = (ph_m[t] + 1) % d_m;
          end
        end

        // Config is only changed while the input is idle, so clearing here
        // is equivalent to the DUT clearing one edge later.
        if (clampd(int'(decim_factor)) != d_m) begin
          d_m = clampd(int'(decim_factor));
          for (int c = 0; c < NCH; c++) begin ph_m[c] = 0; oc_m[c] = 0; end
        end
      end
    end
  endtask

  task automatic set_decim(input int v);
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(negedge aclk);
    decim_factor = DECW'(v);
    @(negedge aclk);
    check("cfg_rdy_low", 32'(s_axis_tready), 32'(0));
    @(negedge aclk);
    check("cfg_rdy_back", 32'(s_axis_tready), 32'(1));
  endtask

  task automatic send(input int tid, input int data, input logic last);
    logic ok = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tid    = TW'(tid);
    s_axis_tdata  = DW'(data);
    s_axis_tlast  = last;
    for (int k = 0; k < 64; k++) begin
      ok = s_axis_tready;
      @(negedge aclk);
      if (ok) break;
    end
    if (!ok) check("send_timeout", 32'(0), 32'(1));
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    repeat (4) @(negedge aclk);
    check("queue_empty", 32'(exp_q.size()), 32'(0));
  endtask

  vec_t tbl[16];

  initial begin
    int    a0;
    logic  ok;
    logic  rdy_last;
    int    nv;

    for (int i = 0; i < 16; i++)
      tbl[i] = '{tid: 2'd0, data: DW'(i), exp_v: (i % 4 == 0), exp_d: DW'(i)};

    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tid = '0; s_axis_tlast = 1'b0;
    m_axis_tready = 1'b1; decim_factor = DECW'(1);

    fork
      monitor();
      begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset values
    repeat (3) @(negedge aclk);
    check("rst_m_valid", 32'(m_axis_tvalid), 32'(0));
    check("rst_s_ready", 32'(s_axis_tready), 32'(0));
    check("rst_kept", kept_count, 32'(0));
    check("rst_bad", 32'(bad_tid_count), 32'(0));
    check("rst_m_data", 32'({m_axis_tid, m_axis_tlast, m_axis_tdata}), 32'(0));
    aresetn = 1'b1;
    #1 check("rdy_before_edge", 32'(s_axis_tready), 32'(0));
    @(negedge aclk);
    check("rdy_after_edge", 32'(s_axis_tready), 32'(1));

    // Decimation by 4 on channel 0, one output per 4 inputs, one cycle latency
    set_decim(4);
    for (int i = 0; i < 16; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tid    = tbl[i].tid;
      s_axis_tdata  = tbl[i].data;
      @(negedge aclk);
      check("dec_valid", 32'(m_axis_tvalid), 32'(tbl[i].exp_v));
      if (tbl[i].exp_v)
        check("dec_data", 32'({m_axis_tid, m_axis_tdata}), 32'({2'd0, tbl[i].exp_d}));
    end
    s_axis_tvalid = 1'b0;
    drain();
    check("dec_kept_count", kept_count, 32'(4));

    // Interleaved channels at D=2; tid 3 is out of range with 3 channels
    set_decim(2);
    for (int n = 0; n < 8; n++)
      for (int t = 0; t < 4; t++)
        send(t, 100 * t + n, 1'b0);
    drain();
    check("il_kept_count", kept_count, 32'(16));
    check("il_bad_tid", 32'(bad_tid_count), 32'(8));

    // Framing at D=1 on channel 1; input tlast is random and must be ignored
    set_decim(1);
    ch1_last_bits = '0;
    for (int i = 0; i < 8; i++) send(1, 700 + i, 1'($urandom_range(0, 1)));
    drain();
    check("frame_tlast", 32'(ch1_last_bits), 32'(8'b0001_0001));

    // Backpressure: output stalled for 5 cycles with continuous input
    m_axis_tready = 1'b0;
    a0 = acc_count;
    s_axis_tvalid = 1'b1; s_axis_tid = 2'd2; s_axis_tdata = DW'(500);
    for (int k = 0; k < 5; k++) begin
      ok = s_axis_tready;
      @(negedge aclk);
      if (ok) s_axis_tdata = s_axis_tdata + 1'b1;
    end
    check("bp_accepts", 32'(acc_count - a0), 32'(2));
    check("bp_rdy_low", 32'(s_axis_tready), 32'(0));
    check("bp_out_hold", 32'(m_axis_tdata), 32'(500));
    m_axis_tready = 1'b1;
    for (int k = 0; k < 50 && s_axis_tdata < DW'(506); k++) begin
      ok = s_axis_tready;
      @(negedge aclk);
      if (ok) s_axis_tdata = s_axis_tdata + 1'b1;
    end
    drain();
    check("bp_total", 32'(acc_count - a0), 32'(6));
    check("bp_kept_count", kept_count, 32'(30));

    // Config change mid-stream: D=4 for 3 samples then D=2
    set_decim(4);
    for (int i = 0; i < 3; i++) send(0, 900 + i, 1'b0);
    set_decim(2);
    for (int i = 0; i < 4; i++) send(0, 910 + i, 1'b0);
    drain();
    check("cfg_kept_count", kept_count, 32'(33));

    // Clamping: 0 acts as 1, 25 acts as MAX_DECIM
    set_decim(0);
    for (int i = 0; i < 3; i++) send(2, 950 + i, 1'b0);
    set_decim(25);
    for (int i = 0; i < 17; i++) send(0, 1000 + i, 1'b0);
    drain();
    check("clamp_kept_count", kept_count, 32'(38));

    // Randomized traffic against the model
    s_axis_tvalid = 1'b0;
    rdy_last = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) begin
        do nv = $urandom_range(0, 31); while (clampd(nv) == d_m);
        set_decim(nv);
        rdy_last = 1'b0;
      end
      if (!s_axis_tvalid || rdy_last) begin
        s_axis_tvalid = 1'($urandom_range(0, 3) != 0);
        s_axis_tid    = TW'($urandom_range(0, 3));
        s_axis_tdata  = DW'($urandom_range(0, 65535));
        s_axis_tlast  = 1'($urandom_range(0, 1));
      end
      m_axis_tready = 1'($urandom_range(0, 2) != 0);
      rdy_last = s_axis_tready;
      @(negedge aclk);
    end
    drain();
    check("rand_kept_count", kept_count, 32'(kept_m));
    check("rand_bad_count", 32'(bad_tid_count), 32'(bad_m));

    // Asynchronous reset with a full buffer
    if (d_m != 1) set_decim(1);
    m_axis_tready = 1'b0;
    send(0, 11, 1'b0);
    send(1, 22, 1'b0);
    check("full_rdy_low", 32'(s_axis_tready), 32'(0));
    check("full_m_valid", 32'(m_axis_tvalid), 32'(1));
    #2 aresetn = 1'b0;
    #1;
    check("arst_m_valid", 32'(m_axis_tvalid), 32'(0));
    check("arst_kept", kept_count, 32'(0));
    check("arst_bad", 32'(bad_tid_count), 32'(0));
    check("arst_rdy", 32'(s_axis_tready), 32'(0));
    @(negedge aclk);
    aresetn = 1'b1;
    m_axis_tready = 1'b1;
    @(negedge aclk);
    check("arst_rdy_back", 32'(s_axis_tready), 32'(1));
    check("arst_m_valid_after", 32'(m_axis_tvalid), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
